// File: rtl/lcd_pkg.sv
// Shared constants and type definitions for the character-LCD refresh engine.
package lcd_pkg;

    // HD44780 "set DDRAM address" commands for the start of each display line.
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    // Width of the strobe timing counter.
    localparam int TMR_W = 16;

    // Character index width: must count 0..64 inclusive.
    localparam int IDX_W = 7;

    // Top-level sequencing states. SETUP/EHIGH/WAIT live inside the
    // strobe timer; the top-level FSM waits for them in ST_STROBE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_STROBE,
        ST_DONE
    } state_e;

    // Strobe timer phases.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHIGH,
        PH_WAIT
    } phase_e;

    // Cursor command for the line about to be written.
    function automatic logic [7:0] line_cmd(input logic second_line);
        return second_line ? CMD_LINE2 : CMD_LINE1;
    endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Generates the SETUP / E-high / execution-wait sequence for one LCD bus write.
// A single-cycle go_i starts the sequence; ready_o pulses in the last WAIT cycle
// so the caller can move on at the same edge the timer returns to idle.
module lcd_strobe_timer
    import lcd_pkg::*;
#(
    parameter int T_SU  = 2,
    parameter int T_PW  = 12,
    parameter int T_CYC = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_i,
    output logic lcd_e_o,
    output logic ready_o
);

    phase_e             phase_q, phase_d;
    logic [TMR_W-1:0]   cnt_q,   cnt_d;
    logic               e_q,     e_d;

    // Next-phase logic: each phase loads its length minus one and counts down to zero.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        phase_d = phase_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        unique case (phase_q)
            PH_IDLE: begin
                if (go_i) begin
                    phase_d = PH_SETUP;
                    cnt_d   = TMR_W'(T_SU - 1);
                end
            end
            PH_SETUP: begin
                if (cnt_q == '0) begin
                    phase_d = PH_EHIGH;
                    cnt_d   = TMR_W'(T_PW - 1);
                    e_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                end
            end
            PH_EHIGH: begin
                if (cnt_q == '0) begin
                    phase_d = PH_WAIT;
                    cnt_d   = TMR_W'(T_CYC - 1);
                    e_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                end
            end
            PH_WAIT: begin
                if (cnt_q == '0) begin
                    phase_d = PH_IDLE;
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                end
            end
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = '0;
                e_d     = 1'b0;
            end
        endcase
    end

    // Phase, counter and enable registers; E is a flop so it cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
        end
    end

    assign lcd_e_o = e_q;
    assign ready_o = (phase_q == PH_WAIT) && (cnt_q == '0);

endmodule

// File: rtl/lcd_refresh_engine.sv
// Streams the character RAM to an HD44780 LCD: line-1 command, first half of
// the characters, line-2 command, second half. Bus timing is delegated to
// lcd_strobe_timer; this level owns the RAM handshake, the character index and
// the insertion of the two cursor commands.
module lcd_refresh_engine
    import lcd_pkg::*;
#(
    parameter int N_CHARS = 32,
    parameter int T_SU    = 2,
    parameter int T_PW    = 12,
    parameter int T_CYC   = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [5:0] ram_addr,
    output logic       ram_ce,
    output logic       ram_we,
    input  logic [7:0] ram_data_r,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam int HALF = N_CHARS / 2;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    // Set when the next LATCH writes a cursor command rather than a character.
    logic               cmd_q,   cmd_d;
    logic [7:0]         db_q,    db_d;
    logic               rs_q,    rs_d;
    logic [5:0]         addr_q,  addr_d;
    logic               ce_q,    ce_d;
    logic               go;
    logic               ready;

    lcd_strobe_timer #(
        .T_SU  (T_SU),
        .T_PW  (T_PW),
        .T_CYC (T_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_i    (go),
        .lcd_e_o (lcd_e),
        .ready_o (ready)
    );

    // Next-state logic: chooses the next write once the timer finishes the current one.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        db_d    = db_q;
        rs_d    = rs_q;
        addr_d  = addr_q;
        ce_d    = 1'b0;
        go      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LATCH;
                    idx_d   = '0;
                    cmd_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                // RAM captured the address at this edge; data is valid during LATCH.
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                go      = 1'b1;
                state_d = ST_STROBE;
                if (cmd_q) begin
                    db_d  = line_cmd(idx_q != '0);
                    rs_d  = 1'b0;
                    cmd_d = 1'b0;
                end else begin
                    db_d  = ram_data_r;
                    rs_d  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_STROBE: begin
                if (ready) begin
                    if (idx_q == IDX_W'(N_CHARS)) begin
                        state_d = ST_DONE;
                    end else if (idx_q == IDX_W'(HALF) && rs_q) begin
                        // First half just finished with a character: insert line 2.
                        state_d = ST_LATCH;
                        cmd_d   = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        ce_d    = 1'b1;
                        addr_d  = idx_q[5:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and registered bus/RAM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cmd_q   <= 1'b0;
            db_q    <= '0;
            rs_q    <= 1'b0;
            addr_q  <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            db_q    <= db_d;
            rs_q    <= rs_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
        end
    end

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign ram_addr = addr_q;
    assign ram_ce   = ce_q;
    assign ram_we   = 1'b0;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_db   = db_q;

endmodule

// File: tb/tb_lcd_refresh_engine.sv
// Bench for lcd_refresh_engine: a small instance (4 chars, short timing) for
// sequence, strobe, handshake, start-filtering and reset checks, and a 64-char
// instance with short timing for line-2 insertion and latency.
module tb_lcd_refresh_engine;

    localparam int LAT   = 4 * (2 + 1 + 2 + 3) + 2 * (1 + 1 + 2 + 3);  // 46
    localparam int LAT_B = 64 * (2 + 1 + 1 + 1) + 2 * (1 + 1 + 1 + 1); // 328

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, ram_ce, ram_we, lcd_rs, lcd_rw, lcd_e;
    logic [5:0] ram_addr;
    logic [7:0] ram_data_r, lcd_db;

    logic       start_b = 1'b0;
    logic       busy_b, done_b, ram_ce_b, ram_we_b, lcd_rs_b, lcd_rw_b, lcd_e_b;
    logic [5:0] ram_addr_b;
    logic [7:0] ram_data_r_b, lcd_db_b;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int t0       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    lcd_refresh_engine #(.N_CHARS(4), .T_SU(1), .T_PW(2), .T_CYC(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we), .ram_data_r(ram_data_r),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    lcd_refresh_engine #(.N_CHARS(64), .T_SU(1), .T_PW(1), .T_CYC(1)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .ram_addr(ram_addr_b), .ram_ce(ram_ce_b), .ram_we(ram_we_b), .ram_data_r(ram_data_r_b),
        .lcd_rs(lcd_rs_b), .lcd_rw(lcd_rw_b), .lcd_e(lcd_e_b), .lcd_db(lcd_db_b)
    );

    // RAM models: address latched on a chip-enabled edge, read combinationally.
    logic [7:0] mem   [64];
    logic [7:0] mem_b [64];
    logic [5:0] lat_a = '0;
    logic [5:0] lat_b = '0;
    always @(posedge clk) begin
        if (ram_ce)   lat_a <= ram_addr;
        if (ram_ce_b) lat_b <= ram_addr_b;
    end
    assign ram_data_r   = mem[lat_a];
    assign ram_data_r_b = mem_b[lat_b];

    // Bus monitor for the small instance.
    typedef struct { logic rs; logic [7:0] db; int rise; int chg; } wr_t;
    typedef struct { logic [5:0] addr; int rel; } fe_t;
    wr_t  wq[$];
    int   widthq[$];
    fe_t  fq[$];
    int   tied_bad = 0;
    logic prev_e = 1'b0, prev_rs = 1'b0;
    logic [7:0] prev_db = '0;
    int   last_chg = 0, cur_rise = 0;

    always @(negedge clk) begin
        int rel;
        rel = ncyc - t0;
        if (lcd_db !== prev_db || lcd_rs !== prev_rs) last_chg = rel;
        if (lcd_e && !prev_e) begin
            wq.push_back('{rs: lcd_rs, db: lcd_db, rise: rel, chg: last_chg});
            cur_rise = rel;
        end
        if (!lcd_e && prev_e) widthq.push_back(rel - cur_rise);
        if (ram_ce) fq.push_back('{addr: ram_addr, rel: rel});
        if (ram_we !== 1'b0 || lcd_rw !== 1'b0 || ram_we_b !== 1'b0 || lcd_rw_b !== 1'b0)
            tied_bad++;
        prev_e  = lcd_e;
        prev_db = lcd_db;
        prev_rs = lcd_rs;
    end

    // Write log for the large instance.
    logic [8:0] bq[$];
    logic prev_e_b = 1'b0;
    always @(negedge clk) begin
        if (lcd_e_b && !prev_e_b) bq.push_back({lcd_rs_b, lcd_db_b});
        prev_e_b = lcd_e_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wq.delete();
        widthq.delete();
        fq.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = ncyc;
        start = 1'b0;
    endtask

    // One refresh on the small instance; extra_a/extra_b are the relative
    // cycles at whose end start is re-driven high (-1 = none).
    task automatic run_refresh(input int extra_a, input int extra_b, output int done_rel,
                               output int busy_low, output int done_cnt, output int late_busy);
        done_rel = -1; busy_low = 0; done_cnt = 0; late_busy = 0;
        pulse_start();
        for (int c = 0; c < LAT + 16; c++) begin
            @(negedge clk);
            start = (c == extra_a || c == extra_b);
            if (c < LAT && !busy) busy_low++;
            if (c >= LAT && busy) late_busy++;
            if (done) begin
                done_cnt++;
                done_rel = c;
            end
        end
        start = 1'b0;
    endtask

    typedef struct { int addr; logic [7:0] ram_in; logic rs; logic [7:0] db; int rise; } vec_t;
    vec_t vecs[6];

    task automatic check_sequence(input string tag);
        int fi;
        fi = 0;
        check({tag, "_nwrites"}, wq.size(), 6);
        check({tag, "_nfetch"}, fq.size(), 4);
        for (int i = 0; i < 6; i++) begin
            if (i < wq.size()) begin
                check($sformatf("%s_w%0d_rs", tag, i), wq[i].rs, vecs[i].rs);
                check($sformatf("%s_w%0d_db", tag, i), wq[i].db, vecs[i].db);
                check($sformatf("%s_w%0d_rise", tag, i), wq[i].rise, vecs[i].rise);
                check($sformatf("%s_w%0d_setup_ok", tag, i), (wq[i].rise - wq[i].chg) >= 1, 1);
            end
            if (i < widthq.size())
                check($sformatf("%s_w%0d_epw", tag, i), widthq[i], 2);
            if (vecs[i].addr >= 0) begin
                if (fi < fq.size()) begin
                    check($sformatf("%s_f%0d_addr", tag, fi), fq[fi].addr, vecs[i].addr);
                    check($sformatf("%s_f%0d_rel", tag, fi), fq[fi].rel, vecs[i].rise - 3);
                end
                fi++;
            end
        end
    endtask

    initial begin
        int done_rel, busy_low, done_cnt, late_busy, cnt, mism;
        logic [8:0] exp_w;

        // Write list of one refresh, with the RAM byte feeding each character.
        vecs[0] = '{addr: -1, ram_in: 8'h00, rs: 1'b0, db: 8'h80, rise: 2};
        vecs[1] = '{addr:  0, ram_in: 8'h41, rs: 1'b1, db: 8'h41, rise: 10};
        vecs[2] = '{addr:  1, ram_in: 8'h42, rs: 1'b1, db: 8'h42, rise: 18};
        vecs[3] = '{addr: -1, ram_in: 8'h00, rs: 1'b0, db: 8'hC0, rise: 25};
        vecs[4] = '{addr:  2, ram_in: 8'h43, rs: 1'b1, db: 8'h43, rise: 33};
        vecs[5] = '{addr:  3, ram_in: 8'h44, rs: 1'b1, db: 8'h44, rise: 41};
        for (int i = 0; i < 64; i++) begin
            mem[i]   = 8'h00;
            mem_b[i] = 8'(i + 8'h20);
        end
        for (int i = 0; i < 6; i++)
            if (vecs[i].addr >= 0) mem[vecs[i].addr] = vecs[i].ram_in;

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ce", ram_ce, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_e", lcd_e, 0);
        check("rst_db", lcd_db, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean refresh: sequence, strobe timing, handshake, latency.
        clear_logs();
        run_refresh(-1, -1, done_rel, busy_low, done_cnt, late_busy);
        check_sequence("r1");
        check("r1_done_rel", done_rel, LAT);
        check("r1_done_cnt", done_cnt, 1);
        check("r1_busy_low", busy_low, 0);
        check("r1_idle_busy", late_busy, 0);
        check("r1_hold_db", lcd_db, 8'h44);
        check("r1_hold_rs", lcd_rs, 1);
        check("r1_hold_addr", ram_addr, 3);
        check("r1_ce_idle", ram_ce, 0);

        // start re-pulsed mid-refresh and in the done cycle: ignored.
        clear_logs();
        run_refresh(4, LAT, done_rel, busy_low, done_cnt, late_busy);
        check_sequence("r2");
        check("r2_done_rel", done_rel, LAT);
        check("r2_done_cnt", done_cnt, 1);
        check("r2_busy_low", busy_low, 0);
        check("r2_no_requeue", late_busy, 0);

        // Reset during E-high of the 0x42 write.
        clear_logs();
        pulse_start();
        for (int c = 0; c <= 18; c++) @(negedge clk);
        check("rr_e_before", lcd_e, 1);
        check("rr_db_before", lcd_db, 8'h42);
        #2 rst_n = 1'b0;
        #1;
        check("rr_e_async", lcd_e, 0);
        check("rr_db_async", lcd_db, 0);
        check("rr_rs_async", lcd_rs, 0);
        check("rr_busy_async", busy, 0);
        check("rr_addr_async", ram_addr, 0);
        check("rr_ce_async", ram_ce, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy || done) cnt++;
        end
        check("rr_idle_busy", cnt, 0);
        check("rr_idle_writes", wq.size(), 0);
        check("rr_idle_fetch", fq.size(), 0);
        run_refresh(-1, -1, done_rel, busy_low, done_cnt, late_busy);
        check_sequence("rr");
        check("rr_done_rel", done_rel, LAT);

        // 64-character instance: line-2 insertion and latency.
        bq.delete();
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        t0      = ncyc;
        start_b = 1'b0;
        done_rel = -1;
        for (int c = 0; c < LAT_B + 20; c++) begin
            @(negedge clk);
            if (done_b && done_rel < 0) done_rel = c;
        end
        check("big_nwrites", bq.size(), 66);
        check("big_done_rel", done_rel, LAT_B);
        mism = 0;
        for (int k = 0; k < 66; k++) begin
            if (k == 0)       exp_w = {1'b0, 8'h80};
            else if (k == 33) exp_w = {1'b0, 8'hC0};
            else if (k < 33)  exp_w = {1'b1, 8'(8'h20 + k - 1)};
            else              exp_w = {1'b1, 8'(8'h20 + k - 2)};
            if (k >= bq.size() || bq[k] !== exp_w) mism++;
        end
        check("big_seq_mismatches", mism, 0);
        if (bq.size() > 34) begin
            check("big_before_c0", bq[32], {1'b1, 8'h3F});
            check("big_c0", bq[33], {1'b0, 8'hC0});
            check("big_after_c0", bq[34], {1'b1, 8'h40});
        end else begin
            check("big_c0_present", bq.size(), 66);
        end

        check("tied_low", tied_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
